// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive FSMs.
//   UART_DATA_W  : data bits per frame (8)
//   UART_DIV_W   : width of the baud divisor (20)
//   UART_MIN_DIV : smallest usable bit period in clk cycles (2)
//   uart_tx_state_t and ST_* : one-hot TX FSM state encoding.
// Optional build macro: UART_TX_PARITY_EN adds the PARI state, which widens
// the state vector to 5 bits.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_DIV_W   = 20;
  localparam int UART_MIN_DIV = 2;

`ifdef UART_TX_PARITY_EN
  localparam int UART_TX_ST_W = 5;
`else
  localparam int UART_TX_ST_W = 4;
`endif

  typedef logic [UART_TX_ST_W-1:0] uart_tx_state_t;

  localparam uart_tx_state_t ST_IDLE = UART_TX_ST_W'(1);
  localparam uart_tx_state_t ST_STAR = UART_TX_ST_W'(2);
  localparam uart_tx_state_t ST_TXDA = UART_TX_ST_W'(4);
  localparam uart_tx_state_t ST_STOP = UART_TX_ST_W'(8);
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t ST_PARI = UART_TX_ST_W'(16);
`endif

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: bit-period timer for the UART transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; the counter is held at 0 while en is low, so
//              every rise of en starts a fresh bit period from 0
//   div      : bit period P in clk cycles (caller guarantees P >= 2)
//   bit_end  : high during the last cycle (count P-1) of each bit period
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q;

  assign bit_end = en && (cnt_q == (div - DIV_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1 UART transmitter fed from a first-word-fall-through FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   baudrate_i   : clk cycles per bit; values below 2 are treated as 2,
//                  sampled once per frame at launch
//   tx_en_i      : allow new frames to launch (a running frame always ends)
//   empty_i      : FIFO empty; tx_data_i is the FIFO head when low
//   rd_en_o      : FIFO pop strobe, combinational, one cycle per byte
//   tx_o         : serial line (registered, idles high)
//   busy_o       : frame in progress (registered)
//   tx_done_o    : combinational pulse in the last stop-bit cycle
// Optional build macro: UART_TX_PARITY_EN adds input parity_odd_i
// (0 = even, 1 = odd) and a parity bit between the data bits and the stop bit.
//
// Handshake: a byte moves from the FIFO whenever rd_en_o is high on a clk
// edge; rd_en_o is only raised while empty_i is low, so the FIFO never sees
// a pop it cannot honour.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DIV_W  = UART_DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baudrate_i,
  input  logic              tx_en_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] tx_data_i,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd_i,
`endif
  output logic              rd_en_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              tx_done_o
);

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              bit_end;
  logic              launch_ok;
  logic              pop;
  logic              done;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_tx_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != ST_IDLE),
    .div     (div_q),
    .bit_end (bit_end)
  );

  // rst is folded in so the pop strobe stays low for the whole reset window.
  assign launch_ok = tx_en_i && !empty_i && !rst;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    pop     = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (launch_ok) begin
          pop     = 1'b1;
          state_d = ST_STAR;
        end
      end
      ST_STAR: begin
        if (bit_end) begin
          state_d = ST_TXDA;
          idx_d   = 3'd0;
        end
      end
      ST_TXDA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARI;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARI: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done = 1'b1;
          // Back-to-back: the next start bit follows the stop bit directly.
          if (launch_ok) begin
            pop     = 1'b1;
            state_d = ST_STAR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d = tx_data_i;
      div_d   = (baudrate_i < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : baudrate_i;
`ifdef UART_TX_PARITY_EN
      par_d   = (^tx_data_i) ^ parity_odd_i;
`endif
    end

    // The line register is loaded from the next state so tx_o changes on the
    // same edge as the state it belongs to.
    case (state_d)
      ST_STAR: tx_d = 1'b0;
      ST_TXDA: tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARI: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= DIV_W'(UART_MIN_DIV);
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rd_en_o   = pop;
  assign tx_done_o = done;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: bench for uart_tx_fsm. A queue-based FIFO feeds the DUT;
// a line model expands every launched byte into its per-cycle bit stream and
// compares tx_o, busy_o, rd_en_o and tx_done_o every cycle.
module tb_uart_tx_fsm;

  logic        clk;
  logic        rst;
  logic [19:0] baudrate_i;
  logic        tx_en_i;
  logic        empty_i;
  logic [7:0]  tx_data_i;
  logic        rd_en_o;
  logic        tx_o;
  logic        busy_o;
  logic        tx_done_o;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd_i;
`endif

  uart_tx_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .baudrate_i (baudrate_i),
    .tx_en_i    (tx_en_i),
    .empty_i    (empty_i),
    .tx_data_i  (tx_data_i),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i (parity_odd_i),
`endif
    .rd_en_o    (rd_en_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .tx_done_o  (tx_done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] fifo[$];
  logic [0:0] exp_q[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         model_pops = 0;
  int         dut_pops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Whole frame as the line should show it, one entry per clk cycle.
  task automatic push_frame(input logic [7:0] d, input logic [19:0] b);
    int p;
    p = (b < 20'd2) ? 2 : int'(b);
    for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < p; k++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < p; k++) exp_q.push_back((^d) ^ parity_odd_i);
`endif
    for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
  endtask

  // scoreboard: sample at negedge, FIFO moves just after posedge
  initial begin
    logic do_pop;
    int   rem;
    forever begin
      @(negedge clk);
      cyc++;
      do_pop = 1'b0;
      if (rst) begin
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rd_en", 32'(rd_en_o), 32'd0);
        check("rst_done", 32'(tx_done_o), 32'd0);
        exp_q.delete();
      end else begin
        rem = exp_q.size();
        do_pop = tx_en_i && (fifo.size() > 0) && (rem <= 1);
        check("tx", 32'(tx_o), (rem > 0) ? 32'(exp_q[0]) : 32'd1);
        check("busy", 32'(busy_o), 32'(rem > 0));
        check("rd_en", 32'(rd_en_o), 32'(do_pop));
        check("done", 32'(tx_done_o), 32'(rem == 1));
        if (rd_en_o) begin
          dut_pops++;
          pop_cyc.push_back(cyc);
        end
        if (rem > 0) void'(exp_q.pop_front());
        if (do_pop) begin
          push_frame(fifo[0], baudrate_i);
          model_pops++;
        end
      end
      @(posedge clk);
      #1;
      if (do_pop) void'(fifo.pop_front());
      #1;
      empty_i   = (fifo.size() == 0);
      tx_data_i = (fifo.size() == 0) ? 8'h00 : fifo[0];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input int budget);
    int start;
    int n;
    start = model_pops;
    n = 0;
    while (model_pops == start && n < budget) begin
      tick();
      n++;
    end
    check("pop_wait", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (((fifo.size() > 0) && tx_en_i) || (exp_q.size() > 0) || (n < 2)) begin
      if (n >= budget) break;
      tick();
      n++;
    end
    check("drain_wait", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int p0;
    int c0;
    rst        = 1'b1;
    baudrate_i = 20'd16;
    tx_en_i    = 1'b0;
    empty_i    = 1'b1;
    tx_data_i  = 8'h00;
`ifdef UART_TX_PARITY_EN
    parity_odd_i = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // single byte, P=16
    p0 = dut_pops;
    tx_en_i = 1'b1;
    baudrate_i = 20'd16;
    fifo.push_back(8'hA5);
    wait_drain(400);
    check("single_pops", 32'(dut_pops - p0), 32'd1);

    // back-to-back, P=4, pops exactly one frame (40 cycles) apart
    p0 = dut_pops;
    c0 = pop_cyc.size();
    baudrate_i = 20'd4;
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    wait_drain(200);
    check("b2b_pops", 32'(dut_pops - p0), 32'd2);
    if (pop_cyc.size() >= c0 + 2)
      check("b2b_spacing", 32'(pop_cyc[c0+1] - pop_cyc[c0]), 32'd40);

    // gating: enable low with data waiting
    p0 = dut_pops;
    tx_en_i = 1'b0;
    fifo.push_back(8'h3C);
    repeat (1000) tick();
    check("gated_pops", 32'(dut_pops - p0), 32'd0);
    fifo.push_back(8'h99);
    baudrate_i = 20'd16;
    tx_en_i = 1'b1;
    wait_pop(50);
    repeat (49) tick();
    tx_en_i = 1'b0;
    wait_drain(400);
    check("gate_mid_pops", 32'(dut_pops - p0), 32'd1);
    check("gate_fifo_left", 32'(fifo.size()), 32'd1);
    fifo.delete();
    tick();

    // reset at cycle 70 of a 0x55 frame
    p0 = dut_pops;
    fifo.push_back(8'h55);
    tx_en_i = 1'b1;
    wait_pop(50);
    repeat (69) tick();
    rst = 1'b1;
    fifo.delete();
    #1;
    check("async_rst_tx", 32'(tx_o), 32'd1);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (50) tick();
    check("rst_pops", 32'(dut_pops - p0), 32'd1);

    // divisor floor and mid-frame divisor change
    baudrate_i = 20'd0;
    fifo.push_back(8'h81);
    wait_drain(100);
    baudrate_i = 20'd1;
    fifo.push_back(8'h6E);
    wait_drain(100);
    c0 = pop_cyc.size();
    baudrate_i = 20'd8;
    fifo.push_back(8'hC3);
    fifo.push_back(8'h5A);
    wait_pop(50);
    repeat (29) tick();
    baudrate_i = 20'd32;
    wait_drain(800);
    if (pop_cyc.size() >= c0 + 2)
      check("div_change_spacing", 32'(pop_cyc[c0+1] - pop_cyc[c0]), 32'd80);
    check("div_change_pops", 32'(pop_cyc.size() - c0), 32'd2);

`ifdef UART_TX_PARITY_EN
    baudrate_i = 20'd4;
    parity_odd_i = 1'b0;
    fifo.push_back(8'h07);
    wait_drain(200);
    parity_odd_i = 1'b1;
    fifo.push_back(8'h07);
    wait_drain(200);
`endif

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0 && fifo.size() < 4) fifo.push_back(8'($urandom));
      if ($urandom_range(0, 59) == 0) tx_en_i = ~tx_en_i;
      if ($urandom_range(0, 79) == 0) baudrate_i = 20'($urandom_range(0, 9));
`ifdef UART_TX_PARITY_EN
      if ($urandom_range(0, 99) == 0) parity_odd_i = ~parity_odd_i;
`endif
      tick();
    end
    tx_en_i = 1'b1;
    wait_drain(3000);
    check("final_idle", 32'(busy_o), 32'd0);
    check("pop_total", 32'(dut_pops), 32'(model_pops));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
